ramp_profile_gen: RTL and testbench

- Parametrised successor to the single-slope phase ramp used by the coil drive.
- Produces a per-drive-cycle phase value that moves from a runtime-loaded start to a runtime-loaded end with a fixed-point step, one step per cycle_done.
- Supports four profile modes: rise, fall, rise-dwell-fall (triangle) and step, each with a programmable dwell.
- Sits between the control/config registers and the phase-shift modulator.

---
 rtl/ramp_profile_gen.sv | 189 ++++++++++++++++++
 tb/tb_ramp_profile_gen.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_profile_gen.sv
// ramp_profile_gen: phase ramp generator for the coil drive.
// Moves a fixed-point accumulator from a start phase to an end phase, one
// step per cycle_done. It supports rise, fall, triangle and step profiles,
// each with a programmable dwell at the target.
// Optional build macro RAMPGEN_ROUND_EN: round the displayed phase half-up
// (clamped at the active target) instead of truncating it.
module ramp_profile_gen #(
    parameter int PHASE_W = 8,
    parameter int FRAC_W  = 8,
    parameter int DWELL_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      cycle_done,
    input  logic [1:0]                cfg_mode,
    input  logic [PHASE_W-1:0]        cfg_start_phase,
    input  logic [PHASE_W-1:0]        cfg_end_phase,
    input  logic [PHASE_W+FRAC_W-1:0] cfg_step,
    input  logic [DWELL_W-1:0]        cfg_dwell,
    output logic [PHASE_W-1:0]        phase_value,
    output logic                      busy,
    output logic                      at_end,
    output logic                      done
);
    localparam int ACC_W = PHASE_W + FRAC_W + 1;
    localparam logic [1:0] M_RISE = 2'b00, M_FALL = 2'b01, M_TRI = 2'b10, M_STEP = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RISE, S_FALL, S_DWELL} state_t;

    state_t                    r_state, w_state_nxt;
    logic [ACC_W-1:0]          r_acc, w_acc_nxt;
    logic [PHASE_W-1:0]        r_phase, w_phase_nxt;
    logic                      r_done, w_done_nxt;
    logic [DWELL_W-1:0]        r_dcnt, w_dcnt_nxt;

    // Config copy held for the whole profile
    logic [1:0]                r_mode;
    logic [PHASE_W-1:0]        r_start, r_end;
    logic [PHASE_W+FRAC_W-1:0] r_step;
    logic [DWELL_W-1:0]        r_dwell;

    logic [PHASE_W-1:0]        w_target, w_ramp_int, w_ramp_phase;
    logic [ACC_W-1:0]          w_sum, w_diff, w_tgt_acc;
    logic                      w_exit;

    // Second leg of a triangle falls back to the latched start; otherwise aim at end
    assign w_target  = (r_state == S_FALL && r_mode == M_TRI) ? r_start : r_end;
    assign w_tgt_acc = {1'b0, w_target, {FRAC_W{1'b0}}};
    assign w_sum     = r_acc + {1'b0, r_step};
    assign w_diff    = r_acc - {1'b0, r_step};
    assign w_ramp_int = (r_state == S_RISE) ? w_sum[ACC_W-2:FRAC_W] : w_diff[ACC_W-2:FRAC_W];

`ifdef RAMPGEN_ROUND_EN
    logic             w_ramp_half;
    logic [PHASE_W:0] w_rnd;
    assign w_ramp_half = (r_state == S_RISE) ? w_sum[FRAC_W-1] : w_diff[FRAC_W-1];
    // Round half up. Only a rising leg can be pushed past its target by rounding.
    always_comb begin
        w_rnd = {1'b0, w_ramp_int} + {{PHASE_W{1'b0}}, w_ramp_half};
        if (r_state == S_RISE && w_rnd > {1'b0, w_target})
            w_ramp_phase = w_target;
        else
            w_ramp_phase = w_rnd[PHASE_W-1:0];
    end
`else
    assign w_ramp_phase = w_ramp_int;
`endif

    // Latch configuration on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= M_RISE;
            r_start <= '0;
            r_end   <= '0;
            r_step  <= '0;
            r_dwell <= '0;
        end else if (start && !abort) begin
            r_mode  <= cfg_mode;
            r_start <= cfg_start_phase;
            r_end   <= cfg_end_phase;
            r_step  <= cfg_step;
            r_dwell <= cfg_dwell;
        end
    end

    // State, accumulator, phase output, dwell counter and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_phase <= '0;
            r_done  <= 1'b0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_phase <= w_phase_nxt;
            r_done  <= w_done_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // Next-state logic: abort beats start, start beats cycle_done
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_phase_nxt = r_phase;
        w_done_nxt  = 1'b0;
        w_dcnt_nxt  = r_dcnt;
        w_exit      = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_phase_nxt = '0;
        end else if (start) begin
            w_acc_nxt   = {1'b0, cfg_start_phase, {FRAC_W{1'b0}}};
            w_phase_nxt = cfg_start_phase;
            case (cfg_mode)
                M_FALL: w_state_nxt = S_FALL;
                M_STEP: begin
                    // Step mode jumps straight to the target and dwells there
                    w_state_nxt = S_DWELL;
                    w_acc_nxt   = {1'b0, cfg_end_phase, {FRAC_W{1'b0}}};
                    w_phase_nxt = cfg_end_phase;
                    w_dcnt_nxt  = cfg_dwell;
                end
                default: w_state_nxt = S_RISE;
            endcase
        end else begin
            case (r_state)
                S_RISE: if (cycle_done) begin
                    // The carry bit means the step ran past full scale
                    if (w_sum[ACC_W-1] || w_sum[ACC_W-2:FRAC_W] >= w_target) begin
                        w_acc_nxt   = w_tgt_acc;
                        w_phase_nxt = w_target;
                        w_state_nxt = S_DWELL;
                        w_dcnt_nxt  = r_dwell;
                    end else begin
                        w_acc_nxt   = w_sum;
                        w_phase_nxt = w_ramp_phase;
                    end
                end
                S_FALL: if (cycle_done) begin
                    // The borrow bit means the step went below zero
                    if (w_diff[ACC_W-1] || w_diff[ACC_W-2:FRAC_W] <= w_target) begin
                        w_acc_nxt   = w_tgt_acc;
                        w_phase_nxt = w_target;
                        if (r_mode == M_TRI) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_DWELL;
                            w_dcnt_nxt  = r_dwell;
                        end
                    end else begin
                        w_acc_nxt   = w_diff;
                        w_phase_nxt = w_ramp_phase;
                    end
                end
                S_DWELL: begin
                    // A zero dwell leaves on the next clock without waiting for cycle_done
                    if (r_dcnt == '0) begin
                        w_exit = 1'b1;
                    end else if (cycle_done) begin
                        w_dcnt_nxt = r_dcnt - 1'b1;
                        w_exit     = (r_dcnt == {{(DWELL_W-1){1'b0}}, 1'b1});
                    end
                    if (w_exit) begin
                        if (r_mode == M_TRI) begin
                            w_state_nxt = S_FALL;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign phase_value = r_phase;
    assign busy        = (r_state != S_IDLE);
    assign at_end      = (r_state == S_DWELL);
    assign done        = r_done;

endmodule

// File: tb/tb_ramp_profile_gen.sv
// Bench for ramp_profile_gen: directed profile scenarios plus a randomized run
// checked cycle by cycle against an arithmetic reference model.
module tb_ramp_profile_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, cycle_done = 1'b0;
    logic [1:0]  cfg_mode = 2'b00;
    logic [7:0]  cfg_start_phase = '0, cfg_end_phase = '0;
    logic [15:0] cfg_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic [7:0]  phase_value;
    logic        busy, at_end, done;

    int n_chk = 0;
    int n_fail = 0;

    ramp_profile_gen #(.PHASE_W(8), .FRAC_W(8), .DWELL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cycle_done(cycle_done),
        .cfg_mode(cfg_mode), .cfg_start_phase(cfg_start_phase), .cfg_end_phase(cfg_end_phase),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
        .phase_value(phase_value), .busy(busy), .at_end(at_end), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input int s, input int e, input int st, input int dw);
        cfg_mode = m; cfg_start_phase = 8'(s); cfg_end_phase = 8'(e);
        cfg_step = 16'(st); cfg_dwell = 16'(dw);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_cd();
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // ---------------- reference model (fixed-point position as a plain integer) ----------------
    localparam int L_IDLE = 0, L_UP = 1, L_DOWN = 2, L_HOLD = 3;
    int m_leg = L_IDLE, m_pos = 0, m_phase = 0, m_cnt = 0, m_done = 0;
    int l_mode = 0, l_start = 0, l_end = 0, l_step = 0, l_dwell = 0;

    function automatic int shown(input int pos, input int tgt, input bit up);
`ifdef RAMPGEN_ROUND_EN
        int r;
        r = (pos + 128) / 256;
        if (up && r > tgt) r = tgt;
        return r;
`else
        if (tgt < 0 || up) return pos / 256;
        return pos / 256;
`endif
    endfunction

    task automatic model_step(input bit a, input bit s, input bit cd);
        int nxt, tgt;
        bit fin;
        m_done = 0;
        if (a) begin
            m_leg = L_IDLE; m_pos = 0; m_phase = 0;
        end else if (s) begin
            l_mode = int'(cfg_mode); l_start = int'(cfg_start_phase); l_end = int'(cfg_end_phase);
            l_step = int'(cfg_step); l_dwell = int'(cfg_dwell);
            m_pos = l_start * 256; m_phase = l_start;
            if (l_mode == 1) m_leg = L_DOWN;
            else if (l_mode == 3) begin
                m_leg = L_HOLD; m_pos = l_end * 256; m_phase = l_end; m_cnt = l_dwell;
            end else m_leg = L_UP;
        end else begin
            case (m_leg)
                L_UP: if (cd) begin
                    nxt = m_pos + l_step;
                    if (nxt / 256 >= l_end) begin
                        m_pos = l_end * 256; m_phase = l_end; m_leg = L_HOLD; m_cnt = l_dwell;
                    end else begin
                        m_pos = nxt; m_phase = shown(nxt, l_end, 1'b1);
                    end
                end
                L_DOWN: if (cd) begin
                    tgt = (l_mode == 2) ? l_start : l_end;
                    nxt = m_pos - l_step;
                    if (nxt < 0 || nxt / 256 <= tgt) begin
                        m_pos = tgt * 256; m_phase = tgt;
                        if (l_mode == 2) begin m_leg = L_IDLE; m_done = 1; end
                        else begin m_leg = L_HOLD; m_cnt = l_dwell; end
                    end else begin
                        m_pos = nxt; m_phase = shown(nxt, tgt, 1'b0);
                    end
                end
                L_HOLD: begin
                    fin = 1'b0;
                    if (m_cnt == 0) fin = 1'b1;
                    else if (cd) begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) fin = 1'b1;
                    end
                    if (fin) begin
                        if (l_mode == 2) m_leg = L_DOWN;
                        else begin m_leg = L_IDLE; m_done = 1; end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        n_chk++;
        if (phase_value !== 8'd0 || busy !== 1'b0 || at_end !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in: phase=%0d busy=%b at_end=%b done=%b, expected all 0", phase_value, busy, at_end, done);
        end
        #10 rst_n = 1'b1;
        tick();
        n_chk++;
        if (phase_value !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: phase=%0d busy=%b done=%b, expected 0/0/0", phase_value, busy, done);
        end
    endtask

    task automatic test_rise();
        int exp_ph[5];
`ifdef RAMPGEN_ROUND_EN
        exp_ph = '{100, 103, 105, 108, 110};
`else
        exp_ph = '{100, 102, 105, 107, 110};
`endif
        do_start(2'b00, 100, 110, 16'h0280, 2);
        n_chk++;
        if (phase_value !== 8'(exp_ph[0]) || busy !== 1'b1 || at_end !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_start: phase=%0d busy=%b at_end=%b, expected %0d/1/0", phase_value, busy, at_end, exp_ph[0]);
        end
        for (int i = 1; i < 5; i++) begin
            do_cd();
            n_chk++;
            if (phase_value !== 8'(exp_ph[i]) || at_end !== (i == 4) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL rise_step%0d: phase=%0d at_end=%b done=%b, expected %0d/%0d/0", i, phase_value, at_end, done, exp_ph[i], (i == 4));
            end
        end
        do_cd();
        n_chk++;
        if (at_end !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_dwell1: at_end=%b done=%b, expected 1/0", at_end, done);
        end
        do_cd();
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0 || at_end !== 1'b0 || phase_value !== 8'd110) begin
            n_fail++;
            $display("FAIL rise_done: done=%b busy=%b at_end=%b phase=%0d, expected 1/0/0/110", done, busy, at_end, phase_value);
        end
        tick();
        n_chk++;
        if (done !== 1'b0 || phase_value !== 8'd110) begin
            n_fail++;
            $display("FAIL rise_done_pulse: done=%b phase=%0d, expected 0/110", done, phase_value);
        end
    endtask

    task automatic test_triangle();
        do_start(2'b10, 10, 20, 16'h0500, 0);
        do_cd();
        n_chk++;
        if (phase_value !== 8'd15) begin n_fail++; $display("FAIL tri_up1: phase=%0d expected 15", phase_value); end
        do_cd();
        n_chk++;
        if (phase_value !== 8'd20 || at_end !== 1'b1) begin
            n_fail++; $display("FAIL tri_peak: phase=%0d at_end=%b expected 20/1", phase_value, at_end);
        end
        tick();
        n_chk++;
        if (at_end !== 1'b0 || busy !== 1'b1 || phase_value !== 8'd20) begin
            n_fail++; $display("FAIL tri_dwell0: at_end=%b busy=%b phase=%0d expected 0/1/20", at_end, busy, phase_value);
        end
        do_cd();
        n_chk++;
        if (phase_value !== 8'd15 || done !== 1'b0) begin
            n_fail++; $display("FAIL tri_down1: phase=%0d done=%b expected 15/0", phase_value, done);
        end
        do_cd();
        n_chk++;
        if (phase_value !== 8'd10 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL tri_done: phase=%0d done=%b busy=%b expected 10/1/0", phase_value, done, busy);
        end
    endtask

    task automatic test_fall_clamp();
        do_start(2'b01, 3, 0, 16'h0200, 5);
        do_cd();
        n_chk++;
        if (phase_value !== 8'd1) begin n_fail++; $display("FAIL fall_step: phase=%0d expected 1", phase_value); end
        do_cd();
        n_chk++;
        if (phase_value !== 8'd0 || at_end !== 1'b1) begin
            n_fail++; $display("FAIL fall_borrow: phase=%0d at_end=%b expected 0/1", phase_value, at_end);
        end
        do_abort();
        do_start(2'b01, 3, 1, 16'h0200, 0);
        do_cd();
        n_chk++;
        if (phase_value !== 8'd1 || at_end !== 1'b1) begin
            n_fail++; $display("FAIL fall_clamp_end1: phase=%0d at_end=%b expected 1/1", phase_value, at_end);
        end
        tick();
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL fall_done: done=%b busy=%b expected 1/0", done, busy);
        end
    endtask

    task automatic test_abort_priority();
        do_start(2'b00, 100, 110, 16'h0280, 2);
        do_cd();
        do_cd();
        n_chk++;
        if (phase_value !== 8'd105) begin n_fail++; $display("FAIL abort_pre: phase=%0d expected 105", phase_value); end
        do_abort();
        n_chk++;
        if (phase_value !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_mid_rise: phase=%0d busy=%b done=%b expected 0/0/0", phase_value, busy, done);
        end
        do_start(2'b00, 50, 60, 16'h0100, 1);
        abort = 1'b1;
        do_start(2'b00, 70, 90, 16'h0100, 1);
        abort = 1'b0;
        n_chk++;
        if (phase_value !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_and_start: phase=%0d busy=%b done=%b expected 0/0/0", phase_value, busy, done);
        end
        do_start(2'b11, 5, 50, 16'h0100, 3);
        n_chk++;
        if (phase_value !== 8'd50 || at_end !== 1'b1) begin
            n_fail++; $display("FAIL step_mode: phase=%0d at_end=%b expected 50/1", phase_value, at_end);
        end
        do_start(2'b00, 7, 9, 16'h0100, 0);
        n_chk++;
        if (phase_value !== 8'd7 || busy !== 1'b1 || at_end !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL restart_dwell: phase=%0d busy=%b at_end=%b done=%b expected 7/1/0/0", phase_value, busy, at_end, done);
        end
        tick();
        n_chk++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL restart_no_done: done=%b expected 0", done); end
    endtask

    task automatic test_async_reset();
        do_start(2'b00, 100, 110, 16'h0280, 2);
        do_cd();
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (phase_value !== 8'd0 || busy !== 1'b0 || at_end !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: phase=%0d busy=%b at_end=%b done=%b expected 0", phase_value, busy, at_end, done);
        end
        rst_n = 1'b1;
        tick();
        do_cd();
        n_chk++;
        if (phase_value !== 8'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_cd_ignored: phase=%0d busy=%b expected 0/0", phase_value, busy);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_abort();
        model_step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            abort      = ($urandom_range(0, 63) == 0);
            start      = ($urandom_range(0, 15) == 0);
            cycle_done = ($urandom_range(0, 1) == 0);
            cfg_mode        = 2'($urandom_range(0, 3));
            cfg_start_phase = 8'($urandom_range(0, 255));
            cfg_end_phase   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'(int'(cfg_start_phase) + $urandom_range(0, 12) - 6);
            cfg_step  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0700));
            cfg_dwell = 16'($urandom_range(0, 3));
            model_step(abort, start, cycle_done);
            tick();
            n_chk++;
            if (phase_value !== 8'(m_phase) || busy !== (m_leg != L_IDLE) ||
                at_end !== (m_leg == L_HOLD) || done !== m_done[0]) begin
                n_fail++;
                errs++;
                if (errs < 10)
                    $display("FAIL random[%0d]: phase=%0d busy=%b at_end=%b done=%b, expected %0d/%0d/%0d/%0d",
                             i, phase_value, busy, at_end, done, m_phase, (m_leg != L_IDLE), (m_leg == L_HOLD), m_done);
            end
        end
        abort = 1'b0; start = 1'b0; cycle_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rise();
        test_triangle();
        test_fall_clamp();
        test_abort_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
